// File: rtl/sram_bist_pkg.sv
// Shared types and constants for the SRAM LFSR BIST: state encoding,
// SRAM geometry, LFSR tap masks and the default seeds.
package sram_bist_pkg;

    localparam int SRAM_ADDR_W = 11;
    localparam int SRAM_DATA_W = 32;

    // Tap masks: address x^11+x^9+1 (bits 10,8); data bits 31,21,1,0
    localparam logic [SRAM_ADDR_W-1:0] ADDR_TAPS = 11'h500;
    localparam logic [SRAM_DATA_W-1:0] DATA_TAPS = 32'h8020_0003;

    localparam logic [SRAM_ADDR_W-1:0] ADDR_SEED_DEF = 11'h5A3;
    localparam logic [SRAM_DATA_W-1:0] DATA_SEED_DEF = 32'hABCD_E123;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } bist_state_e;

endpackage

// File: rtl/lfsr_fib.sv
// Fibonacci LFSR, left shift with the tap parity entering bit 0.
// load restarts from seed and takes the first step in the same cycle.
module lfsr_fib #(
    parameter int            W        = 11,
    parameter logic [W-1:0]  TAPS     = '0,
    parameter logic [W-1:0]  RST_SEED = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] seed,
    output logic [W-1:0] nxt
);

    logic [W-1:0] q;
    logic [W-1:0] cur;

    // nxt is always the value the next use will see, so callers never
    // present the raw seed.
    assign cur = load ? seed : q;
    assign nxt = {cur[W-2:0], ^(cur & TAPS)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= RST_SEED;
        else if (load || en)
            q <= nxt;
    end

endmodule

// File: rtl/sram_lfsr_bist.sv
// SRAM BIST initiator: writes N_WORDS LFSR words to LFSR addresses, replays
// the same sequence as reads and compares through a READ_LATENCY pipeline.
module sram_lfsr_bist
    import sram_bist_pkg::*;
#(
    parameter int                ADDR_W       = SRAM_ADDR_W,
    parameter int                DATA_W       = SRAM_DATA_W,
    parameter int                N_WORDS      = 20,
    parameter int                READ_LATENCY = 1,
    parameter logic [ADDR_W-1:0] ADDR_SEED    = ADDR_SEED_DEF,
    parameter logic [DATA_W-1:0] DATA_SEED    = DATA_SEED_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got,
    output logic              mem_we,
    output logic              mem_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_MAX = (N_WORDS > READ_LATENCY) ? N_WORDS : READ_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(N_WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(READ_LATENCY - 1);

    bist_state_e state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              busy_d, done_d, pass_d, we_d, oe_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              lfsr_load, lfsr_en, push, clear;
    logic [ADDR_W-1:0] a_nxt;
    logic [DATA_W-1:0] d_nxt;

    logic [READ_LATENCY:0]             vld_pipe;
    logic [READ_LATENCY:0][DATA_W-1:0] exp_pipe;
    logic [READ_LATENCY:0][ADDR_W-1:0] addr_pipe;

    logic              mismatch;
    logic [ADDR_W:0]   err_d;
    logic [ADDR_W-1:0] fail_addr_d;
    logic [DATA_W-1:0] fail_exp_d, fail_got_d;

    lfsr_fib #(.W(ADDR_W), .TAPS(ADDR_TAPS), .RST_SEED(ADDR_SEED)) u_addr_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .en   (lfsr_en),
        .seed (ADDR_SEED),
        .nxt  (a_nxt)
    );

    lfsr_fib #(.W(DATA_W), .TAPS(DATA_TAPS), .RST_SEED(DATA_SEED)) u_data_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .en   (lfsr_en),
        .seed (DATA_SEED),
        .nxt  (d_nxt)
    );

    // All port outputs are registered; this block computes their values for
    // the next cycle, so each LFSR step lands on the bus at the same edge.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        busy_d    = busy;
        done_d    = 1'b0;
        pass_d    = pass;
        we_d      = 1'b0;
        oe_d      = 1'b0;
        addr_d    = mem_addr;
        wdata_d   = mem_wdata;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        push      = 1'b0;
        clear     = 1'b0;
        case (state)
            ST_IDLE: if (start) begin
                state_d   = ST_WRITE;
                cnt_d     = '0;
                busy_d    = 1'b1;
                pass_d    = 1'b0;
                clear     = 1'b1;
                lfsr_load = 1'b1;
                we_d      = 1'b1;
                addr_d    = a_nxt;
                wdata_d   = d_nxt;
            end
            ST_WRITE: if (cnt == LAST_WORD) begin
                // Re-seed and issue the first read with no bubble
                state_d   = ST_READ;
                cnt_d     = '0;
                lfsr_load = 1'b1;
                oe_d      = 1'b1;
                addr_d    = a_nxt;
                push      = 1'b1;
            end else begin
                cnt_d   = cnt + 1'b1;
                lfsr_en = 1'b1;
                we_d    = 1'b1;
                addr_d  = a_nxt;
                wdata_d = d_nxt;
            end
            ST_READ: begin
                oe_d = 1'b1;
                if (cnt == LAST_WORD) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt + 1'b1;
                    lfsr_en = 1'b1;
                    addr_d  = a_nxt;
                    push    = 1'b1;
                end
            end
            ST_DRAIN: if (cnt == LAST_DRAIN) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                pass_d  = (err_d == '0);
            end else begin
                cnt_d = cnt + 1'b1;
                oe_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            mem_we    <= 1'b0;
            mem_oe    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            mem_we    <= we_d;
            mem_oe    <= oe_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
        end
    end

    // Stage 0 lines up with the address on the bus; stage READ_LATENCY
    // lines up with the returning mem_rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            exp_pipe  <= '0;
            addr_pipe <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[READ_LATENCY-1:0], push};
            exp_pipe  <= {exp_pipe[READ_LATENCY-1:0], d_nxt};
            addr_pipe <= {addr_pipe[READ_LATENCY-1:0], a_nxt};
        end
    end

    always_comb begin
        err_d       = err_count;
        fail_addr_d = fail_addr;
        fail_exp_d  = fail_exp;
        fail_got_d  = fail_got;
        mismatch    = vld_pipe[READ_LATENCY] && (mem_rdata != exp_pipe[READ_LATENCY]);
        if (clear) begin
            err_d       = '0;
            fail_addr_d = '0;
            fail_exp_d  = '0;
            fail_got_d  = '0;
        end else if (mismatch) begin
            if (err_count != '1)
                err_d = err_count + 1'b1;
            if (err_count == '0) begin
                fail_addr_d = addr_pipe[READ_LATENCY];
                fail_exp_d  = exp_pipe[READ_LATENCY];
                fail_got_d  = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else begin
            err_count <= err_d;
            fail_addr <= fail_addr_d;
            fail_exp  <= fail_exp_d;
            fail_got  <= fail_got_d;
        end
    end

endmodule

// File: tb/tb_sram_lfsr_bist.sv
// Bench for sram_lfsr_bist: behavioural SRAMs with fault injection, a
// sequence/outcome reference model and randomized fault runs.
module tb_sram_lfsr_bist;

    localparam int AW = 11, DW = 32, N = 20, RL = 1, RL2 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, start2 = 1'b0;
    always #5 clk = ~clk;

    logic          busy, done, pass, mem_we, mem_oe;
    logic [AW:0]   err_count;
    logic [AW-1:0] fail_addr, mem_addr;
    logic [DW-1:0] fail_exp, fail_got, mem_wdata, mem_rdata;

    logic          busy2, done2, pass2, mem_we2, mem_oe2;
    logic [AW:0]   err_count2;
    logic [AW-1:0] fail_addr2, mem_addr2;
    logic [DW-1:0] fail_exp2, fail_got2, mem_wdata2, mem_rdata2;

    sram_lfsr_bist dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got),
        .mem_we(mem_we), .mem_oe(mem_oe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    sram_lfsr_bist #(.N_WORDS(1), .READ_LATENCY(RL2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err_count2), .fail_addr(fail_addr2), .fail_exp(fail_exp2), .fail_got(fail_got2),
        .mem_we(mem_we2), .mem_oe(mem_oe2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2)
    );

    // Behavioural SRAMs; rdata is random junk whenever no read is landing
    logic [DW-1:0] mem  [2048];
    logic [DW-1:0] flip [2048];
    logic [DW-1:0] mem2 [2048];
    bit            stuck = 1'b0;
    logic [RL-1:0]  rv  = '0;
    logic [RL2-1:0] rv2 = '0;
    logic [DW-1:0]  rd  [RL];
    logic [DW-1:0]  rd2 [RL2];
    logic [DW-1:0]  junk = '0;

    always @(negedge clk) junk = $urandom;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        for (int k = RL-1; k > 0; k--) begin rv[k] <= rv[k-1]; rd[k] <= rd[k-1]; end
        rv[0] <= mem_oe;
        rd[0] <= stuck ? '0 : (mem[mem_addr] ^ flip[mem_addr]);
        if (mem_we2) mem2[mem_addr2] <= mem_wdata2;
        for (int k = RL2-1; k > 0; k--) begin rv2[k] <= rv2[k-1]; rd2[k] <= rd2[k-1]; end
        rv2[0] <= mem_oe2;
        rd2[0] <= mem2[mem_addr2];
    end

    assign mem_rdata  = rv[RL-1]   ? rd[RL-1]   : junk;
    assign mem_rdata2 = rv2[RL2-1] ? rd2[RL2-1] : ~junk;

    // Bus monitor
    int overlap = 0, w2_n = 0, r2_n = 0;
    logic [AW-1:0] w2_a = '0;
    logic [AW-1:0] wa_q[$], ra_q[$];
    logic [DW-1:0] wd_q[$];

    always @(posedge clk) begin
        if ((mem_we && mem_oe) || (mem_we2 && mem_oe2)) overlap <= overlap + 1;
        if (mem_we) begin wa_q.push_back(mem_addr); wd_q.push_back(mem_wdata); end
        if (mem_oe) ra_q.push_back(mem_addr);
        if (mem_we2) begin w2_n <= w2_n + 1; w2_a <= mem_addr2; end
        if (mem_oe2) r2_n <= r2_n + 1;
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference sequence and predicted outcome
    logic [AW-1:0] m_addr [N];
    logic [DW-1:0] m_data [N];
    int            e_err;
    logic [AW-1:0] e_fa;
    logic [DW-1:0] e_fe, e_fg;

    task automatic build_model();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = 11'h5A3;
        d = 32'hABCDE123;
        for (int i = 0; i < N; i++) begin
            a = {a[9:0], a[10] ^ a[8]};
            d = {d[30:0], d[31] ^ d[21] ^ d[1] ^ d[0]};
            m_addr[i] = a;
            m_data[i] = d;
        end
    endtask

    task automatic predict();
        logic [DW-1:0] got;
        e_err = 0; e_fa = '0; e_fe = '0; e_fg = '0;
        for (int i = 0; i < N; i++) begin
            got = stuck ? '0 : (m_data[i] ^ flip[m_addr[i]]);
            if (got != m_data[i]) begin
                if (e_err == 0) begin e_fa = m_addr[i]; e_fe = m_data[i]; e_fg = got; end
                e_err++;
            end
        end
    endtask

    task automatic run_main(input string tag, input int repulse);
        int cyc, wbad, rbad;
        bit seen;
        wa_q.delete(); wd_q.delete(); ra_q.delete();
        predict();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0; seen = 1'b0;
        while (cyc < 200 && !seen) begin
            @(negedge clk); cyc++;
            if (cyc == 1) chk({tag, "_busy"}, busy, 1);
            start = (cyc == repulse);
            seen = done;
        end
        start = 1'b0;
        chk({tag, "_latency"}, cyc, 2*N + RL + 1);
        chk({tag, "_pass"}, pass, e_err == 0);
        chk({tag, "_err_count"}, err_count, e_err);
        chk({tag, "_fail_addr"}, fail_addr, e_fa);
        chk({tag, "_fail_exp"}, fail_exp, e_fe);
        chk({tag, "_fail_got"}, fail_got, e_fg);
        chk({tag, "_n_writes"}, wa_q.size(), N);
        chk({tag, "_n_oe_cycles"}, ra_q.size(), N + RL);
        wbad = 0; rbad = 0;
        for (int i = 0; i < wa_q.size() && i < N; i++)
            if (wa_q[i] != m_addr[i] || wd_q[i] != m_data[i]) wbad++;
        for (int i = 0; i < ra_q.size(); i++)
            if (ra_q[i] != m_addr[(i < N) ? i : N-1]) rbad++;
        chk({tag, "_write_seq"}, wbad, 0);
        chk({tag, "_read_seq"}, rbad, 0);
        @(negedge clk);
        chk({tag, "_done_pulse_busy"}, {done, busy}, 0);
    endtask

    task automatic run_small();
        int cyc;
        bit seen;
        @(negedge clk); w2_n = 0; r2_n = 0; start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        cyc = 0; seen = 1'b0;
        while (cyc < 50 && !seen) begin
            @(negedge clk); cyc++;
            seen = done2;
        end
        chk("small_latency", cyc, 5);
        chk("small_pass", pass2, 1);
        chk("small_err_count", err_count2, 0);
        chk("small_n_writes", w2_n, 1);
        chk("small_n_oe_cycles", r2_n, 1 + RL2);
        chk("small_write_addr", w2_a, 11'h346);
    endtask

    initial begin
        int idx, nflip;
        bit seen;
        build_model();
        for (int i = 0; i < 2048; i++) flip[i] = '0;

        #1;
        chk("reset_outs", |{busy, done, pass, err_count, fail_addr, fail_exp, fail_got,
                            mem_we, mem_oe, mem_addr, mem_wdata}, 0);
        chk("reset_outs2", |{busy2, done2, pass2, err_count2, fail_addr2, fail_exp2, fail_got2,
                             mem_we2, mem_oe2, mem_addr2, mem_wdata2}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_main("t1", 0);
        chk("t1_first_addr", wa_q[0], 11'h346);
        chk("t1_first_data", wd_q[0], 32'h579BC247);

        flip[11'h346] = 32'h1;
        run_main("t2", 0);
        chk("t2_fail_got_const", fail_got, 32'h579BC246);
        flip[11'h346] = '0;

        stuck = 1'b1;
        run_main("t3", 0);
        chk("t3_err_const", err_count, 20);
        stuck = 1'b0;

        for (int r = 0; r < 4; r++) begin
            nflip = $urandom_range(3, 1);
            for (int j = 0; j < nflip; j++) begin
                idx = $urandom_range(N-1, 0);
                flip[m_addr[idx]] = $urandom | (32'h1 << $urandom_range(31, 0));
            end
            flip[$urandom_range(2047, 0)] = $urandom;
            repeat ($urandom_range(4, 0)) @(negedge clk);
            run_main($sformatf("rnd%0d", r), 0);
            for (int i = 0; i < 2048; i++) flip[i] = '0;
        end

        run_small();

        run_main("t5_restart", $urandom_range(N-2, 2));

        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (N + 5) @(negedge clk);
        chk("rst_mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", |{busy, done, pass, err_count, fail_addr, fail_exp, fail_got,
                              mem_we, mem_oe, mem_addr, mem_wdata}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (60) begin @(negedge clk); seen = seen | done; end
        chk("rst_no_done", seen, 0);
        run_main("t5_rerun", 0);

        chk("we_oe_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sram_lfsr_bist.md
Name: sram_lfsr_bist

Overview:
Built-in self-test initiator for the 2048 x 32 single-port SRAM (sram_8kb); it drives the opposite end of that SRAM's we/oe/addr/data_in/data_out interface.
- On a start pulse it writes N pseudo-random words to pseudo-random addresses, using LFSRs.
- It then re-seeds, regenerates the same sequence, reads each word back and compares it against the expected value.
- It reports pass/fail, an error count and details of the first failure.
- It sits between the SoC test controller and the SRAM macro, and owns the SRAM port while busy.

Parameters:
- ADDR_W, 11, SRAM address width (fixed polynomial assumes 11).
- DATA_W, 32, SRAM data width (fixed polynomial assumes 32).
- N_WORDS, 20, words tested per run; legal 1..2047.
- READ_LATENCY, 1, cycles from read address issue (oe=1) to valid mem_rdata; legal 1..3.
- ADDR_SEED, 11'h5A3, address LFSR seed; must be non-zero.
- DATA_SEED, 32'hABCDE123, data LFSR seed; must be non-zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a run; honoured only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse at the end of a run.
- pass  out  1  result of the last run; held until the next start is accepted.
- err_count  out  ADDR_W+1  mismatches in the last run; saturates at all-ones.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_exp  out  DATA_W  expected data at the first mismatch.
- fail_got  out  DATA_W  read data at the first mismatch.
- mem_we  out  1  SRAM write enable.
- mem_oe  out  1  SRAM output enable.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data; Z/X when oe=0, never sampled then.

Behaviour:
- Reset values:
  - All outputs 0 (busy, done, pass, err_count, fail_*, mem_we, mem_oe, mem_addr, mem_wdata).
  - State IDLE.
  - LFSRs loaded with their seeds.
- LFSR step is a left shift with the new bit in bit 0:
  - Address: new bit = a[10]^a[8] (x^11+x^9+1).
  - Data: new bit = d[31]^d[21]^d[1]^d[0].
  - The LFSR advances BEFORE each use, so the first word uses step(seed).
  - The address LFSR is maximal length, so addresses are unique for N_WORDS<=2047 and never 0.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
  - IDLE: start=1 -> reset counters, clear err_count/pass/fail_*, load seeds -> WRITE.
  - WRITE (N_WORDS cycles): mem_we=1, mem_oe=0; mem_addr/mem_wdata = next LFSR values, one word per cycle. After the last write -> READ, with LFSRs re-seeded in the same cycle.
  - READ (N_WORDS cycles): mem_we=0, mem_oe=1; mem_addr = next address LFSR value. The expected data and address go into a READ_LATENCY-deep pipeline with a valid bit.
  - DRAIN (READ_LATENCY cycles): mem_oe=1, mem_we=0, mem_addr held; the pipeline empties.
  - DONE (1 cycle): done=1; pass=(err_count==0); mem_oe=0 -> IDLE.
  - Latency: done is high exactly 2*N_WORDS+READ_LATENCY+1 cycles after the start-sampling edge.
- Compare:
  - When the pipeline output is valid, compare mem_rdata with the expected data.
  - On mismatch, err_count increments (saturating).
  - If err_count was 0 before the mismatch, capture fail_addr/exp/got.
- The WRITE->READ boundary has no idle cycle, and we and oe are never both high.
- start while busy is ignored, with no restart.
- rst mid-run aborts immediately: all outputs return to reset values and no done pulse is issued.
- mem_addr/mem_wdata hold their last value outside active cycles; mem_we=mem_oe=0 in IDLE.

Decomposition:
- Package sram_bist_pkg holds:
  - The state enum.
  - ADDR_W/DATA_W constants.
  - Tap constants (address 10/8; data 31/21/1/0).
  - The default seeds.
- One natural sub-module, lfsr_fib: parameterised width and tap mask, with load/seed/enable inputs; instantiated twice (address and data).
- The compare pipeline and FSM stay in the top module.

Test Plan:
1. Defaults, against a behavioural SRAM with 1-cycle read; start at cycle 3 -> first write has mem_addr=11'h346, mem_wdata=32'h579BC247. Then 20 writes, 20 reads at identical addresses in order; done 42 cycles after start; pass=1, err_count=0.
2. SRAM model flips bit 0 at address 11'h346 on readback -> pass=0, err_count=1, fail_addr=11'h346, fail_exp=32'h579BC247, fail_got=32'h579BC246.
3. Stuck-at-zero data bus on every read -> err_count=20. fail_* show the first word only.
4. N_WORDS=1, READ_LATENCY=2 -> exactly one write and one read; done 5 cycles after start; pass=1.
5. start re-pulsed mid-WRITE -> ignored, with no change in sequence or timing. rst asserted mid-READ -> outputs immediately 0, no done; a subsequent start reruns from the seeds and passes.
6. Monitor throughout all runs: mem_we&mem_oe never 1; mem_rdata never sampled while mem_oe=0 (an X/Z rdata model causes no false error).
